// File: rtl/ss_sequencer.sv
// Save-state sequencer: streams the mapper ss register window out to the host (save)
// or from the host into the mapper (load), with every bus access paced by m2 falling edges.
module ss_sequencer #(
    parameter int unsigned REG_CNT     = 128,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned M2_TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m2,
    input  logic       cmd_save,
    input  logic       cmd_load,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] out_dat,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_dat,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat
);
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DAT_W  = 8;
    localparam int unsigned CNT_W  = $clog2(M2_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_CNT - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(M2_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ALIGN   = 3'd1,
        RD_WAIT = 3'd2,
        RD_OUT  = 3'd3,
        LD_IN   = 3'd4,
        WR_ARM  = 3'd5,
        WR_HOLD = 3'd6,
        FIN     = 3'd7
    } state_e;

    state_e                  state_q, state_d;
    logic                    mode_save_q, mode_save_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic                    m2_prev_q, m2_prev_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [DAT_W-1:0]        out_dat_q, out_dat_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;
    logic                    ss_act_q, ss_act_d;
    logic                    ss_we_q, ss_we_d;
    logic [ADDR_W-1:0]       ss_addr_q, ss_addr_d;
    logic [DAT_W-1:0]        ss_wdat_q, ss_wdat_d;

    logic fall_c;
    logic timed_c;
    logic timeout_c;
    logic last_c;

    assign fall_c  = m2_prev_q & ~sync_q[SYNC_STAGES-1];
    assign timed_c = (state_q == ALIGN) || (state_q == RD_WAIT) ||
                     (state_q == WR_ARM) || (state_q == WR_HOLD);
    assign timeout_c = timed_c && !fall_c && (cnt_q == CNT_LAST);
    assign last_c  = (ss_addr_q == LAST_ADDR);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        mode_save_d = mode_save_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], m2};
        m2_prev_d   = sync_q[SYNC_STAGES-1];
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        out_dat_d   = out_dat_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        ss_act_d    = ss_act_q;
        ss_we_d     = ss_we_q;
        ss_addr_d   = ss_addr_q;
        ss_wdat_d   = ss_wdat_q;

        // Host stalls (RD_OUT, LD_IN) leave the watchdog frozen
        if (fall_c) begin
            cnt_d = '0;
        end else if (timed_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_save || cmd_load) begin
                    mode_save_d = cmd_save;
                    state_d     = ALIGN;
                    busy_d      = 1'b1;
                    ss_act_d    = 1'b1;
                    ss_addr_d   = '0;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                end
            end
            ALIGN: begin
                if (fall_c) begin
                    if (mode_save_q) begin
                        state_d = RD_WAIT;
                    end else begin
                        state_d    = LD_IN;
                        in_ready_d = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                if (fall_c) begin
                    out_dat_d   = ss_rdat;
                    out_valid_d = 1'b1;
                    state_d     = RD_OUT;
                end
            end
            RD_OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (last_c) begin
                        state_d = FIN;
                    end else begin
                        ss_addr_d = ss_addr_q + ADDR_W'(1);
                        state_d   = ALIGN;
                    end
                end
            end
            LD_IN: begin
                if (in_valid && in_ready_q) begin
                    ss_wdat_d  = in_dat;
                    in_ready_d = 1'b0;
                    state_d    = WR_ARM;
                end
            end
            WR_ARM: begin
                if (fall_c) begin
                    ss_we_d = 1'b1;
                    state_d = WR_HOLD;
                end
            end
            WR_HOLD: begin
                // Strobe drops first; address/data move one clk later
                if (ss_we_q) begin
                    if (fall_c) begin
                        ss_we_d = 1'b0;
                    end
                end else if (last_c) begin
                    state_d = FIN;
                end else begin
                    ss_addr_d = ss_addr_q + ADDR_W'(1);
                    state_d   = ALIGN;
                end
            end
            FIN: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                ss_act_d  = 1'b0;
                ss_addr_d = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort or watchdog expiry: drop the bus immediately, no done
        if ((state_q != IDLE) && (abort || timeout_c)) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            ss_we_d     = 1'b0;
            ss_act_d    = 1'b0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b0;
            cnt_d       = '0;
            err_d       = err_q | timeout_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_save_q <= 1'b0;
            sync_q      <= '0;
            m2_prev_q   <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_dat_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            ss_act_q    <= 1'b0;
            ss_we_q     <= 1'b0;
            ss_addr_q   <= '0;
            ss_wdat_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_save_q <= mode_save_d;
            sync_q      <= sync_d;
            m2_prev_q   <= m2_prev_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            out_dat_q   <= out_dat_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            ss_act_q    <= ss_act_d;
            ss_we_q     <= ss_we_d;
            ss_addr_q   <= ss_addr_d;
            ss_wdat_q   <= ss_wdat_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign out_dat   = out_dat_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign ss_act    = ss_act_q;
    assign ss_we     = ss_we_q;
    assign ss_addr   = ss_addr_q;
    assign ss_wdat   = ss_wdat_q;

endmodule

// File: tb/tb_ss_sequencer.sv
// Bench for ss_sequencer: a behavioural mapper (register file written on real m2 falls)
// and host streams; checks byte order, write coverage, stalls, timeout, abort and reset.
module tb_ss_sequencer;
    localparam int NREG    = 2;
    localparam int TMO     = 64;
    localparam int BUDGET  = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m2 = 1'b1;
    logic       cmd_save = 1'b0;
    logic       cmd_load = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, err;
    logic [7:0] out_dat;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] in_dat = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       ss_act, ss_we;
    logic [7:0] ss_addr, ss_wdat, ss_rdat;

    int total = 0;
    int bad   = 0;

    bit         m2_run = 1'b1;
    logic [7:0] rd_tab [NREG];
    logic [7:0] mem    [NREG];
    int         wr_cnt [NREG];
    int         pulse_edges = 0;
    int         we_pulses = 0;
    bit         skip_edge_chk = 1'b0;
    logic       prev_we = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    logic [7:0] prev_wdat = 8'h00;
    logic [7:0] got [$];

    typedef struct {
        bit         is_save;
        int         stall0;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;
    vec_t vecs [6];

    ss_sequencer #(
        .REG_CNT    (NREG),
        .SYNC_STAGES(2),
        .M2_TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m2       (m2),
        .cmd_save (cmd_save),
        .cmd_load (cmd_load),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .out_dat  (out_dat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .in_dat   (in_dat),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ss_act   (ss_act),
        .ss_we    (ss_we),
        .ss_addr  (ss_addr),
        .ss_wdat  (ss_wdat),
        .ss_rdat  (ss_rdat)
    );

    always #5 clk = ~clk;

    // m2: 16-clk period, edges offset from clk so it is truly asynchronous
    initial begin
        #3;
        forever begin
            #80;
            if (m2_run) m2 = ~m2;
            else        m2 = 1'b0;
        end
    end

    assign ss_rdat = (ss_addr < 8'(NREG)) ? rd_tab[ss_addr[0]] : 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mapper: latches the write on the real m2 falling edge
    always @(negedge m2) begin
        if (ss_act && ss_we) begin
            mem[ss_addr[0]]    = ss_wdat;
            wr_cnt[ss_addr[0]] = wr_cnt[ss_addr[0]] + 1;
            pulse_edges        = pulse_edges + 1;
        end
    end

    // Strobe monitor: address/data stable around ss_we, one real edge per pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (ss_we || prev_we) begin
                check("ss_addr_stable", 32'(ss_addr), 32'(prev_addr));
                check("ss_wdat_stable", 32'(ss_wdat), 32'(prev_wdat));
            end
            if (ss_we && !prev_we) begin
                we_pulses   = we_pulses + 1;
                pulse_edges = 0;
                check("ss_addr_range", 32'(ss_addr < 8'(NREG)), 32'd1);
            end
            if (!ss_we && prev_we && !skip_edge_chk)
                check("we_pulse_m2_edges", 32'(pulse_edges), 32'd1);
        end
        prev_we   = ss_we;
        prev_addr = ss_addr;
        prev_wdat = ss_wdat;
    end

    task automatic do_save(input int stall0, input bit rand_rdy, input bit both, input bit poke_load);
        int stall;
        bit gap, seen_done, holding;
        logic [7:0] held;
        stall = 0; gap = 0; seen_done = 0; holding = 0; held = 8'h00;
        got.delete();
        we_pulses = 0;
        cmd_save = 1'b1;
        cmd_load = both;
        @(negedge clk);
        cmd_save = 1'b0;
        cmd_load = 1'b0;
        check("save_accept_busy", 32'(busy), 32'd1);
        check("accept_err_clear", 32'(err), 32'd0);
        for (int c = 0; c < BUDGET && !seen_done; c++) begin
            if (done) begin
                seen_done = 1;
            end else begin
                if (!busy || !ss_act) gap = 1;
                if (holding) begin
                    check("out_valid_held", 32'(out_valid), 32'd1);
                    check("out_dat_held", 32'(out_dat), 32'(held));
                end
                cmd_load = poke_load && (c == 20);
                if (out_valid && got.size() == 0 && stall < stall0) begin
                    out_ready = 1'b0;
                    stall++;
                end else begin
                    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (out_valid && out_ready) begin
                    got.push_back(out_dat);
                    holding = 0;
                end else if (out_valid) begin
                    holding = 1;
                    held    = out_dat;
                end else begin
                    holding = 0;
                end
                @(negedge clk);
            end
        end
        cmd_load  = 1'b0;
        out_ready = 1'b1;
        check("save_done_seen", 32'(seen_done), 32'd1);
        check("save_done_busy_low", 32'(busy), 32'd0);
        check("save_done_act_low", 32'(ss_act), 32'd0);
        check("save_err", 32'(err), 32'd0);
        check("save_busy_span", 32'(gap), 32'd0);
        check("save_byte_count", 32'(got.size()), 32'(NREG));
        check("save_no_we", 32'(we_pulses), 32'd0);
        @(negedge clk);
        check("save_done_single", 32'(done), 32'd0);
    endtask

    task automatic do_load(input logic [7:0] b0, input logic [7:0] b1, input bit rand_vld);
        int idx;
        bit gap, seen_done;
        logic [7:0] src [NREG];
        src[0] = b0; src[1] = b1;
        idx = 0; gap = 0; seen_done = 0;
        for (int i = 0; i < NREG; i++) wr_cnt[i] = 0;
        we_pulses = 0;
        cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        check("load_accept_busy", 32'(busy), 32'd1);
        for (int c = 0; c < BUDGET && !seen_done; c++) begin
            if (done) begin
                seen_done = 1;
            end else begin
                if (!busy || !ss_act) gap = 1;
                in_valid = (idx < NREG) && (!rand_vld || ($urandom_range(0, 1) == 1));
                in_dat   = (idx < NREG) ? src[idx] : 8'h00;
                if (in_valid && in_ready) idx++;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        check("load_done_seen", 32'(seen_done), 32'd1);
        check("load_done_busy_low", 32'(busy), 32'd0);
        check("load_bytes_taken", 32'(idx), 32'(NREG));
        check("load_busy_span", 32'(gap), 32'd0);
        check("load_we_pulses", 32'(we_pulses), 32'(NREG));
        for (int i = 0; i < NREG; i++) check("load_one_write_per_addr", 32'(wr_cnt[i]), 32'd1);
        check("load_err", 32'(err), 32'd0);
        @(negedge clk);
        check("load_done_single", 32'(done), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit dn;
        logic err_before;
        logic [7:0] r0, r1;

        vecs[0] = '{1'b1, 0,   8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b0, 0,   8'h02, 8'h81, 8'h02, 8'h81};
        vecs[2] = '{1'b1, 100, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[3] = '{1'b0, 0,   8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[4] = '{1'b1, 0,   8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[5] = '{1'b0, 0,   8'h5A, 8'hC3, 8'h5A, 8'hC3};
        rd_tab[0] = 8'hA5; rd_tab[1] = 8'h3C;
        for (int i = 0; i < NREG; i++) begin mem[i] = 8'h00; wr_cnt[i] = 0; end

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ss_act", 32'(ss_act), 32'd0);
        check("rst_ss_we", 32'(ss_we), 32'd0);
        check("rst_ss_addr", 32'(ss_addr), 32'd0);
        check("rst_ss_wdat", 32'(ss_wdat), 32'd0);
        check("rst_out_dat", 32'(out_dat), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Directed table
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].is_save) begin
                rd_tab[0] = vecs[v].d0; rd_tab[1] = vecs[v].d1;
                do_save(vecs[v].stall0, 1'b0, 1'b0, 1'b0);
                if (got.size() == NREG) begin
                    check("vec_save_byte0", 32'(got[0]), 32'(vecs[v].e0));
                    check("vec_save_byte1", 32'(got[1]), 32'(vecs[v].e1));
                end
            end else begin
                mem[0] = ~vecs[v].e0; mem[1] = ~vecs[v].e1;
                do_load(vecs[v].d0, vecs[v].d1, 1'b0);
                check("vec_load_mem0", 32'(mem[0]), 32'(vecs[v].e0));
                check("vec_load_mem1", 32'(mem[1]), 32'(vecs[v].e1));
            end
            repeat (3) @(negedge clk);
        end

        // Both commands together -> save; cmd_load while busy ignored
        rd_tab[0] = 8'hA5; rd_tab[1] = 8'h3C;
        do_save(0, 1'b0, 1'b1, 1'b1);
        if (got.size() == NREG) begin
            check("both_cmd_byte0", 32'(got[0]), 32'hA5);
            check("both_cmd_byte1", 32'(got[1]), 32'h3C);
        end
        repeat (3) @(negedge clk);

        // m2 stuck low: watchdog fires after TMO clk in ALIGN
        m2_run = 1'b0;
        for (int c = 0; c < 40 && m2; c++) @(negedge clk);
        repeat (6) @(negedge clk);
        cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        check("tmo_busy", 32'(busy), 32'd1);
        cyc = 0; dn = 0;
        while (!err && cyc < 200) begin
            if (done) dn = 1;
            @(negedge clk);
            cyc++;
        end
        check("tmo_latency", 32'(cyc), 32'(TMO));
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_busy_low", 32'(busy), 32'd0);
        check("tmo_we_low", 32'(ss_we), 32'd0);
        check("tmo_act_low", 32'(ss_act), 32'd0);
        check("tmo_in_ready_low", 32'(in_ready), 32'd0);
        check("tmo_no_done", 32'(dn | done), 32'd0);
        repeat (5) @(negedge clk);
        check("tmo_err_sticky", 32'(err), 32'd1);
        m2_run = 1'b1;
        do_save(0, 1'b0, 1'b0, 1'b0);
        if (got.size() == NREG) check("after_tmo_byte0", 32'(got[0]), 32'hA5);
        repeat (3) @(negedge clk);

        // Abort while the write strobe is high
        skip_edge_chk = 1'b1;
        cmd_load = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0;
        in_valid = 1'b1;
        in_dat   = 8'h77;
        cyc = 0;
        while (!ss_we && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("abort_reached_we", 32'(ss_we), 32'd1);
        err_before = err;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_we_low", 32'(ss_we), 32'd0);
        check("abort_act_low", 32'(ss_act), 32'd0);
        check("abort_busy_low", 32'(busy), 32'd0);
        check("abort_err_kept", 32'(err), 32'(err_before));
        check("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort_no_late_done", 32'(done), 32'd0);
        check("abort_stays_idle", 32'(busy), 32'd0);
        skip_edge_chk = 1'b0;
        repeat (3) @(negedge clk);

        // Reset while waiting on the host in RD_OUT
        rd_tab[0] = 8'hA5; rd_tab[1] = 8'h3C;
        out_ready = 1'b0;
        cmd_save = 1'b1;
        @(negedge clk);
        cmd_save = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("rd_out_reached", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_ss_act", 32'(ss_act), 32'd0);
        check("mid_rst_ss_we", 32'(ss_we), 32'd0);
        check("mid_rst_ss_addr", 32'(ss_addr), 32'd0);
        check("mid_rst_ss_wdat", 32'(ss_wdat), 32'd0);
        check("mid_rst_out_dat", 32'(out_dat), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);

        // Random operations against the mapper/host model
        for (int it = 0; it < 16; it++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                rd_tab[0] = r0; rd_tab[1] = r1;
                do_save(int'($urandom_range(0, 20)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
                if (got.size() == NREG) begin
                    check("rand_save_byte0", 32'(got[0]), 32'(rd_tab[0]));
                    check("rand_save_byte1", 32'(got[1]), 32'(rd_tab[1]));
                end
            end else begin
                mem[0] = ~r0; mem[1] = ~r1;
                do_load(r0, r1, 1'b1);
                check("rand_load_mem0", 32'(mem[0]), 32'(r0));
                check("rand_load_mem1", 32'(mem[1]), 32'(r1));
            end
            repeat (int'($urandom_range(1, 7))) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
